// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale conversion stage.
package gray_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUESTING,
    CONVERTING,
    DRAINING,
    DONE
  } gray_state_t;

  localparam int unsigned COEF_R    = 77;
  localparam int unsigned COEF_G    = 150;
  localparam int unsigned COEF_B    = 29;
  localparam int unsigned ROUND_OFS = 128;

endpackage

// File: rtl/grayscale_control_luma_core.sv
// Combinational RGB555 -> 5-bit luma; GRAY_LUMA_ROUND_EN selects rounding
// instead of truncation of the weighted sum.
module luma_core
  import gray_pkg::*;
(
  input  logic [14:0] rgb_i,
  output logic [4:0]  y_o
);

  logic [12:0] s_d;

  // Coefficients sum to 256, so the 13-bit sum cannot overflow even with rounding.
  always_comb begin
    s_d = 13'(COEF_R) * {8'd0, rgb_i[14:10]}
        + 13'(COEF_G) * {8'd0, rgb_i[9:5]}
        + 13'(COEF_B) * {8'd0, rgb_i[4:0]};
`ifdef GRAY_LUMA_ROUND_EN
    s_d = s_d + 13'(ROUND_OFS);
`endif
    y_o = s_d[12:8];
  end

endmodule

// File: rtl/grayscale_control.sv
// Streams a frame from the capture buffer through luma conversion into the
// gray buffer with rq/ack arbitration. Optional macro: GRAY_LUMA_ROUND_EN.
module grayscale_control
  import gray_pkg::*;
#(
  parameter int unsigned depth    = 76800,
  parameter int unsigned addrBits = $clog2(depth)
) (
  input  logic                gray_clk,
  input  logic                reset,
  input  logic                ack_read,
  output logic                rq_read,
  output logic                reading,
  input  logic [14:0]         input_px_rgb,
  output logic [addrBits-1:0] read_addr,
  output logic                read_clk,
  input  logic                ack_write,
  output logic                rq_write,
  output logic                writing,
  output logic [14:0]         output_px_gray,
  output logic [addrBits-1:0] write_addr,
  output logic                write_clk,
  output logic                enable_mem,
  output logic                frame_done
);

  localparam logic [addrBits-1:0] LAST = addrBits'(depth - 1);

  gray_state_t         state_q;
  logic                rq_q, reading_q, writing_q, done_q, drain_q;
  logic [addrBits-1:0] raddr_q, a1_q, waddr_q;
  logic                v1_q, wen_q;
  logic [14:0]         gray_q;
  logic [4:0]          y_d;

  luma_core u_luma (
    .rgb_i (input_px_rgb),
    .y_o   (y_d)
  );

  always_ff @(posedge gray_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rq_q      <= 1'b0;
      reading_q <= 1'b0;
      writing_q <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= 1'b0;
      raddr_q   <= '0;
      a1_q      <= '0;
      v1_q      <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      gray_q    <= '0;
    end else begin
      // Stage 2 retires whatever stage 1 captured; an abort below overrides the strobe.
      wen_q <= v1_q;
      if (v1_q) begin
        waddr_q <= a1_q;
        gray_q  <= {y_d, y_d, y_d};
      end
      v1_q   <= 1'b0;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!ack_read && !ack_write) begin
            state_q <= REQUESTING;
            rq_q    <= 1'b1;
          end
        end
        REQUESTING: begin
          reading_q <= ack_read;
          writing_q <= ack_write;
          if (ack_read && ack_write) begin
            state_q <= CONVERTING;
            raddr_q <= '0;
          end
        end
        CONVERTING, DRAINING: begin
          if (!ack_read || !ack_write) begin
            state_q   <= IDLE;
            rq_q      <= 1'b0;
            reading_q <= 1'b0;
            writing_q <= 1'b0;
            wen_q     <= 1'b0;
            raddr_q   <= '0;
          end else if (state_q == CONVERTING) begin
            v1_q <= 1'b1;
            a1_q <= raddr_q;
            if (raddr_q == LAST) begin
              raddr_q <= '0;
              drain_q <= 1'b0;
              state_q <= DRAINING;
            end else begin
              raddr_q <= raddr_q + addrBits'(1);
            end
          end else begin
            drain_q <= 1'b1;
            if (drain_q) begin
              state_q   <= DONE;
              rq_q      <= 1'b0;
              reading_q <= 1'b0;
              writing_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rq_read        = rq_q;
  assign rq_write       = rq_q;
  assign reading        = reading_q;
  assign writing        = writing_q;
  assign read_addr      = raddr_q;
  assign write_addr     = waddr_q;
  assign output_px_gray = gray_q;
  assign enable_mem     = wen_q;
  assign frame_done     = done_q;
  assign read_clk       = gray_clk;
  assign write_clk      = gray_clk;

endmodule

// File: tb/tb_grayscale_control.sv
// Self-checking bench for grayscale_control with a small frame (depth 16).
module tb_grayscale_control;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NV    = 6;

  logic          gray_clk = 1'b0;
  logic          reset, ack_read, ack_write;
  logic          rq_read, reading, rq_write, writing;
  logic          enable_mem, frame_done, read_clk, write_clk;
  logic [14:0]   input_px_rgb, output_px_gray;
  logic [AW-1:0] read_addr, write_addr;

  logic [14:0] mem [DEPTH];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [14:0] rgb;
    logic [14:0] gray;
  } vec_t;
  vec_t vecs [NV];

  grayscale_control #(.depth(DEPTH)) dut (
    .gray_clk       (gray_clk),
    .reset          (reset),
    .ack_read       (ack_read),
    .rq_read        (rq_read),
    .reading        (reading),
    .input_px_rgb   (input_px_rgb),
    .read_addr      (read_addr),
    .read_clk       (read_clk),
    .ack_write      (ack_write),
    .rq_write       (rq_write),
    .writing        (writing),
    .output_px_gray (output_px_gray),
    .write_addr     (write_addr),
    .write_clk      (write_clk),
    .enable_mem     (enable_mem),
    .frame_done     (frame_done)
  );

  always #5 gray_clk = ~gray_clk;

  // Capture buffer: synchronous read, data one cycle after the address.
  always @(posedge gray_clk) input_px_rgb <= mem[read_addr];

  function automatic logic [14:0] ref_gray(input logic [14:0] p);
    int unsigned s, y;
    s = 77 * int'(p[14:10]) + 150 * int'(p[9:5]) + 29 * int'(p[4:0]);
`ifdef GRAY_LUMA_ROUND_EN
    s = s + 128;
`endif
    y = s / 256;
    return 15'(y * 1024 + y * 32 + y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge gray_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rq_read"}, rq_read, 0);
    check({tag, "_rq_write"}, rq_write, 0);
    check({tag, "_reading"}, reading, 0);
    check({tag, "_writing"}, writing, 0);
    check({tag, "_read_addr"}, read_addr, 0);
    check({tag, "_write_addr"}, write_addr, 0);
    check({tag, "_gray"}, output_px_gray, 0);
    check({tag, "_enable_mem"}, enable_mem, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  task automatic wait_rq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = rq_read && rq_write;
    end
    check("rq_raise", ok, 1);
  endtask

  task automatic wait_raddr(input int unsigned a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (read_addr == AW'(a));
    end
    check("raddr_reached", ok, 1);
  endtask

  // One full frame: grant ack_read, then ack_write wdelay cycles later.
  task automatic run_frame(input int unsigned wdelay);
    bit ok, seen_last;
    int unsigned idx, first_en, last_rd, done_cyc, dones;
    wait_rq(ok);
    if (!ok) return;
    ack_read = 1'b1;
    for (int unsigned i = 0; i < wdelay; i++) begin
      tick();
      check("reading_follows", reading, 1);
      check("writing_waits", writing, 0);
    end
    ack_write = 1'b1;
    idx = 0; first_en = 0; last_rd = 0; done_cyc = 0; dones = 0; seen_last = 1'b0;
    for (int unsigned c = 1; c <= DEPTH + 8; c++) begin
      tick();
      if (enable_mem) begin
        if (idx == 0) first_en = c;
        check("write_addr", write_addr, idx);
        check("gray_model", output_px_gray, ref_gray(mem[idx % DEPTH]));
        if (idx < NV && mem[idx] == vecs[idx].rgb)
          check("gray_vector", output_px_gray, vecs[idx].gray);
        idx++;
      end
      if (!seen_last && read_addr == AW'(DEPTH - 1)) begin
        seen_last = 1'b1;
        last_rd = c;
      end
      if (frame_done) begin
        dones++;
        done_cyc = c;
        check("done_rq_low", rq_read | rq_write | reading | writing, 0);
      end
    end
    check("first_write_latency", first_en, 3);
    check("write_count", idx, DEPTH);
    check("last_read_cycle", last_rd, DEPTH);
    check("frame_done_cycle", done_cyc, last_rd + 3);
    check("frame_done_once", dones, 1);
    ack_read  = 1'b0;
    ack_write = 1'b0;
  endtask

  initial begin
    bit ok, bad;
    vecs[0] = '{15'h7C00, 15'h2529};
    vecs[1] = '{15'h03E0, 15'h4A52};
`ifdef GRAY_LUMA_ROUND_EN
    vecs[2] = '{15'h001F, 15'h1084};
`else
    vecs[2] = '{15'h001F, 15'h0C63};
`endif
    vecs[3] = '{15'h7FFF, 15'h7FFF};
    vecs[4] = '{15'h0000, 15'h0000};
    vecs[5] = '{15'h4210, 15'h4210};

    reset = 1'b1; ack_read = 1'b0; ack_write = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      mem[i] = (i < NV) ? vecs[i].rgb : 15'($urandom);
    tick(); tick();
    check_all_zero("reset");
    @(posedge gray_clk); #1;
    check("read_clk", read_clk, 1);
    check("write_clk", write_clk, 1);

    // Outstanding ack keeps the block in IDLE.
    tick();
    reset = 1'b0; ack_read = 1'b1;
    tick(); tick(); tick();
    check("idle_holds_on_ack", rq_read, 0);
    ack_read = 1'b0;

    run_frame(3);

    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = 15'(i);
    run_frame(0);

    for (int f = 0; f < 4; f++) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
      run_frame($urandom_range(0, 5));
    end

    // Lost grant at pixel 7.
    wait_rq(ok);
    ack_read = 1'b1; ack_write = 1'b1;
    wait_raddr(7, ok);
    ack_write = 1'b0;
    tick();
    check("abort_rq", rq_read | rq_write, 0);
    check("abort_enable", enable_mem, 0);
    check("abort_owned", reading | writing, 0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bad = bad | frame_done | enable_mem;
    end
    check("abort_quiet", bad, 0);
    ack_read = 1'b0;
    run_frame(1);

    // Reset mid-frame.
    wait_rq(ok);
    ack_read = 1'b1; ack_write = 1'b1;
    wait_raddr(5, ok);
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    reset = 1'b0; ack_read = 1'b0; ack_write = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad = bad | enable_mem;
      tick();
    end
    check("post_reset_quiet", bad, 0);
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = 15'($urandom);
    run_frame(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
